// File: rtl/intrude_sched_pkg.sv
// Shared types and defaults for the intrusion DMA scheduler.
package intrude_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSREQ = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NREQ_DEF       = 3;
  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 8;
  localparam int STROBE_LEN_DEF = 3;
  localparam int TIMEOUT_DEF    = 31;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intrude_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer.
module intrude_rr_arb #(
  parameter int NREQ = 3,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0] sum;

  always_comb begin
    id    = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // wide sum so non-power-of-two NREQ wraps cleanly
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!valid && req[sum[ID_W-1:0]]) begin
        valid = 1'b1;
        id    = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/intrude_sched.sv
// Intrusion DMA scheduler: arbitrates NREQ requesters onto one RD/WR strobe burst.
// Optional BUS_ACK timeout enabled by defining INTRUDE_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrate, latch winner's direction/address/data
// BUSREQ | TRUDY high, waiting for BUS_ACK
// ACCESS | RD or WR held for STROBE_LEN cycles
// DONE   | ACK (and ERR on timeout) pulse, bus released, pointer advances
module intrude_sched
  import intrude_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STROBE_LEN = STROBE_LEN_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WR,
  input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0] REQ_DATA,
  output logic [NREQ-1:0]        ACK,
  output logic [DATA_W-1:0]      RDATA,
  output logic                   TRUDY,
  input  logic                   BUS_ACK,
  output logic                   RD,
  output logic                   WR,
  output logic [ADDR_W-1:0]      ADDR,
  output logic [DATA_W-1:0]      DOUT,
  input  logic [DATA_W-1:0]      DIN,
  output logic                   ERR
);

  localparam int ID_W = id_width(NREQ);

  state_t          state, state_nx;
  logic [ID_W-1:0] ptr, winner, arb_id;
  logic            arb_valid;
  logic            wr_q;
  logic [3:0]      scnt;
  logic            to_expire;

  intrude_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (REQ),
    .ptr   (ptr),
    .id    (arb_id),
    .valid (arb_valid)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (arb_valid) state_nx = BUSREQ;
      BUSREQ: begin
        if (BUS_ACK)        state_nx = ACCESS;
        else if (to_expire) state_nx = DONE;
      end
      ACCESS: if (scnt == 4'd0) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      winner <= '0;
      wr_q   <= 1'b0;
      ADDR   <= '0;
      DOUT   <= '0;
      RDATA  <= '0;
      ptr    <= '0;
      scnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (arb_valid) begin
          winner <= arb_id;
          wr_q   <= REQ_WR[arb_id];
          ADDR   <= ADDR_W'(REQ_ADDR >> (int'(arb_id) * ADDR_W));
          DOUT   <= DATA_W'(REQ_DATA >> (int'(arb_id) * DATA_W));
        end
        BUSREQ: if (BUS_ACK) scnt <= 4'(STROBE_LEN - 1);
        ACCESS: begin
          if (scnt == 4'd0) begin
            if (!wr_q) RDATA <= DIN;
          end else begin
            scnt <= scnt - 4'd1;
          end
        end
        DONE: ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef INTRUDE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            timed_out;

  assign to_expire = (state == BUSREQ) && !BUS_ACK && (to_cnt == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt    <= TO_W'(TIMEOUT);
      timed_out <= 1'b0;
    end else if (state == BUSREQ) begin
      if (to_expire)     timed_out <= 1'b1;
      else if (!BUS_ACK) to_cnt    <= to_cnt - 1'b1;
    end
  end

  assign ERR = (state == DONE) && timed_out;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign to_expire      = 1'b0;
  assign ERR            = 1'b0;
`endif

  assign TRUDY = (state == BUSREQ) || (state == ACCESS);
  assign RD    = (state == ACCESS) && !wr_q;
  assign WR    = (state == ACCESS) && wr_q;

  always_comb begin
    ACK = '0;
    if (state == DONE) ACK[winner] = 1'b1;
  end

endmodule

// File: tb/tb_intrude_sched.sv
// Self-checking bench for intrude_sched: directed scenarios plus random traffic vs. a timeline model.
module tb_intrude_sched;

  localparam int NREQ    = 3;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 8;
  localparam int L       = 3;
  localparam int TIMEOUT = 31;
  localparam int AW_T    = NREQ * ADDR_W;
  localparam int DW_T    = NREQ * DATA_W;
`ifdef INTRUDE_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   REQ, REQ_WR, ACK;
  logic [AW_T-1:0]   REQ_ADDR;
  logic [DW_T-1:0]   REQ_DATA;
  logic [DATA_W-1:0] RDATA, DOUT, DIN;
  logic [ADDR_W-1:0] ADDR;
  logic              TRUDY, BUS_ACK, RD, WR, ERR;

  always #5 CLK = ~CLK;

  intrude_sched #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_LEN(L), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .ACK(ACK), .RDATA(RDATA), .TRUDY(TRUDY), .BUS_ACK(BUS_ACK),
    .RD(RD), .WR(WR), .ADDR(ADDR), .DOUT(DOUT), .DIN(DIN), .ERR(ERR)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // transaction timeline model: everything follows from latch / grant / done cycle numbers
  bit                busy;
  int                latch_c, g_c, done_c, w_m, ptr_m;
  bit                wr_m, err_m;
  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] dout_m, rdata_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (((int'(r) >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    busy = 0; ptr_m = 0; rdata_m = '0; addr_m = '0; dout_m = '0;
    g_c = -1; done_c = -1; err_m = 0; wr_m = 0; w_m = 0; latch_c = 0;
  endtask

  task automatic model_edge();
    int w;
    if (!busy) begin
      w = pick(REQ, ptr_m);
      if (w >= 0) begin
        busy = 1; latch_c = cyc; g_c = -1; done_c = -1; err_m = 0; w_m = w;
        wr_m   = ((int'(REQ_WR) >> w) & 1) != 0;
        addr_m = ADDR_W'(REQ_ADDR >> (w * ADDR_W));
        dout_m = DATA_W'(REQ_DATA >> (w * DATA_W));
      end
    end else if (done_c >= 0 && cyc == done_c) begin
      busy = 0;
      ptr_m = (w_m + 1) % NREQ;
    end else if (g_c < 0 && done_c < 0) begin
      if (BUS_ACK) begin
        g_c = cyc; done_c = cyc + L + 1;
      end else if (TO_EN && (cyc - latch_c) == TIMEOUT + 1) begin
        done_c = cyc + 1; err_m = 1;
      end
    end else if (g_c >= 0 && cyc == g_c + L && !wr_m) begin
      rdata_m = DIN;
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] e_ack;
    bit e_tr, e_rd, e_wr, e_err;
    e_ack = '0; e_tr = 0; e_rd = 0; e_wr = 0; e_err = 0;
    if (busy) begin
      if (done_c >= 0 && cyc == done_c) begin
        e_ack = NREQ'(1) << w_m;
        e_err = err_m;
      end else if (g_c < 0) begin
        e_tr = 1;
      end else if (cyc > g_c && cyc <= g_c + L) begin
        e_tr = 1; e_rd = !wr_m; e_wr = wr_m;
      end
    end
    chk("ack",   32'(ACK),   32'(e_ack));
    chk("trudy", 32'(TRUDY), 32'(e_tr));
    chk("rd",    32'(RD),    32'(e_rd));
    chk("wr",    32'(WR),    32'(e_wr));
    chk("err",   32'(ERR),   32'(e_err));
    chk("addr",  32'(ADDR),  32'(addr_m));
    chk("dout",  32'(DOUT),  32'(dout_m));
    chk("rdata", 32'(RDATA), 32'(rdata_m));
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET) model_reset();
    else       model_edge();
    cyc++;
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic wait_ack(input string name, input int budget, output logic [NREQ-1:0] got);
    got = '0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ACK != '0) begin
        got = ACK;
        break;
      end
    end
    if (got == '0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no ACK within %0d cycles", name, budget);
    end
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] v);
    logic [AW_T-1:0] m;
    m = AW_T'({ADDR_W{1'b1}}) << (i * ADDR_W);
    REQ_ADDR = (REQ_ADDR & ~m) | (AW_T'(v) << (i * ADDR_W));
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    logic [DW_T-1:0] m;
    m = DW_T'({DATA_W{1'b1}}) << (i * DATA_W);
    REQ_DATA = (REQ_DATA & ~m) | (DW_T'(v) << (i * DATA_W));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] got;
    logic [NREQ-1:0] rr_exp [4];
    int wr_n, ack_n;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    RESET = 1'b1; REQ = '0; REQ_WR = '0; REQ_ADDR = '0; REQ_DATA = '0;
    BUS_ACK = 1'b0; DIN = '0;
    model_reset();
    #1;
    chk("rst_trudy", 32'(TRUDY), 32'd0);
    chk("rst_ack",   32'(ACK),   32'd0);
    chk("rst_addr",  32'(ADDR),  32'd0);
    chk("rst_rdata", 32'(RDATA), 32'd0);
    repeat (2) step();
    RESET = 1'b0;

    // single read with immediate grant; this negedge starts cycle 1
    set_addr(0, 20'h1A2B3); REQ = 3'b001; REQ_WR = 3'b000; BUS_ACK = 1'b1; DIN = 8'h5C;
    for (int k = 2; k <= 6; k++) begin
      step();
      if (k == 2) chk("t1_trudy", 32'(TRUDY), 32'd1);
      if (k >= 3 && k <= 5) begin
        chk("t1_rd",   32'(RD),   32'd1);
        chk("t1_addr", 32'(ADDR), 32'h1A2B3);
      end
      if (k == 6) begin
        chk("t1_ack",   32'(ACK),   32'b001);
        chk("t1_rdata", 32'(RDATA), 32'h5C);
      end
      chk("t1_wr", 32'(WR), 32'd0);
    end
    REQ = '0;
    step();

    // write with grant delayed 7 cycles after TRUDY
    REQ = 3'b010; REQ_WR = 3'b010; set_data(1, 8'hA5); BUS_ACK = 1'b0;
    step();
    chk("t2_trudy", 32'(TRUDY), 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t2_wr_early", 32'(WR), 32'd0);
    end
    BUS_ACK = 1'b1;
    wr_n = 0; ack_n = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (WR) begin
        wr_n++;
        chk("t2_dout", 32'(DOUT), 32'hA5);
      end
      if (ACK != '0) begin
        ack_n++;
        chk("t2_ack", 32'(ACK), 32'b010);
        REQ = '0;
      end
    end
    chk("t2_wr_len",  32'(wr_n),  32'd3);
    chk("t2_ack_cnt", 32'(ack_n), 32'd1);

    // reset asserted during the second RD cycle
    REQ = 3'b100; REQ_WR = 3'b000; BUS_ACK = 1'b1;
    for (int k = 0; k < 6 && !RD; k++) step();
    step();
    chk("t4_rd_before", 32'(RD), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t4_rd",    32'(RD),    32'd0);
    chk("t4_trudy", 32'(TRUDY), 32'd0);
    chk("t4_ack",   32'(ACK),   32'd0);
    chk("t4_addr",  32'(ADDR),  32'd0);
    model_reset();
    REQ = '0;
    step();
    RESET = 1'b0;

    // all three requesting; pointer restarts at 0 after the reset
    REQ = 3'b111; REQ_WR = 3'b101; BUS_ACK = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wait_ack("t3_wait", 12, got);
      chk("t3_order", 32'(got), 32'(rr_exp[a]));
      chk("t3_gap_trudy", 32'(TRUDY), 32'd0);
    end
    REQ = '0;
    step();

    // request withdrawn right after the latch
    REQ = 3'b001; REQ_WR = 3'b000; DIN = 8'h3E;
    step();
    REQ = '0;
    wait_ack("t6_wait", 12, got);
    chk("t6_ack",   32'(got),   32'b001);
    chk("t6_rdata", 32'(RDATA), 32'h3E);
    step();

`ifdef INTRUDE_SCHED_TIMEOUT_EN
    begin
      int tr_n, rw_n;
      logic [NREQ-1:0] to_ack;
      logic to_err;
      tr_n = 0; rw_n = 0; to_ack = '0; to_err = 1'b0;
      REQ = 3'b100; REQ_WR = 3'b000; BUS_ACK = 1'b0;
      for (int k = 0; k < 50; k++) begin
        step();
        if (TRUDY) tr_n++;
        if (RD || WR) rw_n++;
        if (ACK != '0) begin
          to_ack = ACK; to_err = ERR; REQ = '0;
          break;
        end
      end
      chk("to_trudy_len", 32'(tr_n),   32'd32);
      chk("to_ack",       32'(to_ack), 32'b100);
      chk("to_err",       32'(to_err), 32'd1);
      chk("to_strobes",   32'(rw_n),   32'd0);
      step();
    end
`endif

    // random traffic: requesters hold until ACK, fields churn every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [NREQ-1:0] raise, drop_ack, drop_rand;
      raise     = NREQ'($urandom) & NREQ'($urandom);
      drop_ack  = ACK & NREQ'($urandom);
      drop_rand = (($urandom % 32) == 0) ? NREQ'($urandom) : '0;
      REQ       = (REQ | raise) & ~drop_ack & ~drop_rand;
      REQ_WR    = NREQ'($urandom);
      REQ_ADDR  = AW_T'({$urandom, $urandom});
      REQ_DATA  = DW_T'($urandom);
      DIN       = DATA_W'($urandom);
      BUS_ACK   = ($urandom % 3) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
